dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data accesses (LDUR/STUR).
- Accepts one load or store request at a time over a valid/ready handshake and services it after a fixed, parameterised latency from a word-addressed backing array.
- Returns read data or a write acknowledge, and raises a stall to the hazard logic while a request is outstanding.
- Replaces the zero-latency data memory so the pipeline can be exercised against slow memory.

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package dmem_responder_pkg;

  // Width of the latency down-counter; supports LATENCY up to 15.
  localparam int DMEM_LATSIZE = 4;

  typedef logic [DMEM_LATSIZE-1:0] dmem_cnt_t;

  typedef enum logic [1:0] {
    DMEM_STATE_IDLE = 2'd0,
    DMEM_STATE_WAIT = 2'd1,
    DMEM_STATE_RESP = 2'd2
  } dmem_state_e;

  // A doubleword access must have its three low address bits clear.
  function automatic logic dmem_misaligned(input logic [2:0] addr_lsb);
    return addr_lsb != 3'b000;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x WORDSIZE backing store, sync write, registered read, async clear
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 256,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [WORDSIZE-1:0] wr_data,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [WORDSIZE-1:0] rd_data
);

  logic [WORDSIZE-1:0] mem [DEPTH];

  // Storage and read register; the read register returns zero on any cycle
  // without a read so the response data bus is quiet outside load responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
      end
      rd_data <= rd_en ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_error,
  output logic                stall
);

  localparam int        IDX_W    = $clog2(DEPTH);
  localparam int        IDX_LSB  = 3;
  localparam int        IDX_MSB  = IDX_LSB + IDX_W - 1;
  localparam dmem_cnt_t CNT_LOAD = dmem_cnt_t'(LATENCY - 1);

  dmem_state_e         state_q;
  dmem_state_e         state_d;
  dmem_cnt_t           cnt_q;
  logic                write_q;
  logic [WORDSIZE-1:0] addr_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic                resp_valid_q;
  logic                resp_error_q;

  logic                accept;
  logic                commit;
  logic                addr_err;
  logic [IDX_W-1:0]    word_idx;

  // Decode is done on the latched address so the request bus is free after acceptance.
  assign word_idx = addr_q[IDX_MSB:IDX_LSB];
  assign addr_err = dmem_misaligned(addr_q[2:0]) || (|addr_q[WORDSIZE-1:IDX_MSB+1]);

  // The access happens on the edge that leaves WAIT for RESP.
  assign commit = (state_q == DMEM_STATE_WAIT) && (cnt_q == '0);

  // Next-state, handshake and stall decode.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    stall     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      DMEM_STATE_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = DMEM_STATE_WAIT;
        end
      end
      DMEM_STATE_WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DMEM_STATE_RESP;
        end
      end
      DMEM_STATE_RESP: begin
        state_d = DMEM_STATE_IDLE;
      end
      default: begin
        state_d = DMEM_STATE_IDLE;
      end
    endcase
  end

  // State register, latency counter and latched request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMEM_STATE_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_LOAD;
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if ((state_q == DMEM_STATE_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - dmem_cnt_t'(1);
      end
    end
  end

  // Registered response flags, aligned with the RESP state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      resp_valid_q <= commit;
      resp_error_q <= commit && addr_err;
    end
  end

  dmem_array #(
    .WORDSIZE (WORDSIZE),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (commit && write_q && !addr_err),
    .wr_idx  (word_idx),
    .wr_data (wdata_q),
    .rd_en   (commit && !write_q && !addr_err),
    .rd_idx  (word_idx),
    .rd_data (resp_rdata)
  );

  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int DEP   = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_rv, a_err, a_stall;
  logic [63:0] a_rdata;

  logic        b_valid = 1'b0, b_write = 1'b0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_rv, b_err, b_stall;
  logic [63:0] b_rdata;

  logic [63:0] ref_a [DEP];
  logic [63:0] ref_b [DEP];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WORDSIZE(64), .DEPTH(DEP), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_ready(a_ready), .resp_valid(a_rv), .resp_rdata(a_rdata),
    .resp_error(a_err), .stall(a_stall)
  );

  dmem_responder #(.WORDSIZE(64), .DEPTH(DEP), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_ready(b_ready), .resp_valid(b_rv), .resp_rdata(b_rdata),
    .resp_error(b_err), .stall(b_stall)
  );

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit addr_bad(input logic [63:0] addr);
    return (addr[2:0] != 3'b000) || (addr >= 64'(DEP) * 64'd8);
  endfunction

  function automatic logic [63:0] pick_addr();
    int r;
    logic [63:0] a;
    r = $urandom_range(0, 9);
    if (r < 7)       a = 64'($urandom_range(0, 7)) * 64'd8;
    else if (r == 7) a = 64'($urandom_range(0, 7)) * 64'd8 + 64'($urandom_range(1, 7));
    else if (r == 8) a = 64'd2048 << $urandom_range(0, 50);
    else             a = 64'($urandom_range(0, DEP - 1)) * 64'd8;
    return a;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_models();
    for (int i = 0; i < DEP; i++) begin
      ref_a[i] = '0;
      ref_b[i] = '0;
    end
  endtask

  // Issue one request on instance A. Entry: at a falling edge with A idle,
  // or (chain=1) with A in its response cycle. Exit: at the falling edge of A's response cycle.
  task automatic a_req(input logic w, input logic [63:0] addr, input logic [63:0] data, input bit chain);
    logic [63:0] exp_d;
    logic [63:0] widx;
    bit bad;
    a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = data;
    if (chain) begin
      #1;
      chk(64'(a_ready), 64'd0, "a_ready_during_resp");
      @(negedge clk);
    end
    #1;
    chk(64'(a_ready), 64'd1, "a_ready_idle");
    chk(64'(a_stall), 64'd1, "a_stall_request");
    bad  = addr_bad(addr);
    widx = addr >> 3;
    exp_d = (w || bad) ? 64'd0 : ref_a[widx[7:0]];
    if (w && !bad) ref_a[widx[7:0]] = data;
    @(negedge clk);
    a_valid = 1'b0; a_write = 1'($urandom); a_addr = rnd64(); a_wdata = rnd64();
    #1;
    for (int k = 0; k < LAT_A; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk(64'(a_rv), 64'd0, "a_resp_valid_wait");
      chk(64'(a_ready), 64'd0, "a_ready_wait");
      chk(64'(a_stall), 64'd1, "a_stall_wait");
    end
    @(negedge clk);
    #1;
    chk(64'(a_rv), 64'd1, "a_resp_valid");
    chk(64'(a_err), 64'(bad), "a_resp_error");
    chk(a_rdata, exp_d, "a_resp_rdata");
    chk(64'(a_stall), 64'd0, "a_stall_resp");
    chk(64'(a_ready), 64'd0, "a_ready_resp");
  endtask

  task automatic a_idle();
    @(negedge clk);
    #1;
    chk(64'(a_rv), 64'd0, "a_resp_valid_idle");
    chk(64'(a_ready), 64'd1, "a_ready_back_idle");
    chk(64'(a_stall), 64'd0, "a_stall_idle");
  endtask

  initial begin
    logic [63:0] acc_a, acc_d, widx;
    logic        acc_w, bad, in_resp, c;
    int          ph;
    localparam int P = LAT_B + 2;

    clear_models();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk(64'(a_ready), 64'd1, "rst_ready");
    chk(64'(a_rv), 64'd0, "rst_resp_valid");
    chk(a_rdata, 64'd0, "rst_rdata");
    chk(64'(a_err), 64'd0, "rst_error");
    chk(64'(a_stall), 64'd0, "rst_stall");
    chk(64'(b_ready), 64'd1, "rst_b_ready");
    @(negedge clk);
    rst = 1'b1;
    a_idle();

    // Directed: load of never-written word, store/load back-to-back
    a_req(1'b0, 64'h10, 64'h0, 1'b0);
    a_idle();
    a_req(1'b1, 64'h18, 64'hDEADBEEFCAFEF00D, 1'b0);
    a_req(1'b0, 64'h18, 64'h0, 1'b1);
    a_idle();

    // Misaligned store leaves the array untouched
    a_req(1'b1, 64'h1C, 64'h55, 1'b0);
    a_req(1'b0, 64'h18, 64'h0, 1'b1);
    a_idle();

    // Out-of-range load
    a_req(1'b0, 64'h800, 64'h0, 1'b0);
    a_idle();

    // Reset while a store is waiting: nothing commits, outputs drop immediately
    a_valid = 1'b1; a_write = 1'b1; a_addr = 64'h20; a_wdata = 64'h1234;
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk(64'(a_ready), 64'd1, "async_rst_ready");
    chk(64'(a_rv), 64'd0, "async_rst_resp_valid");
    chk(a_rdata, 64'd0, "async_rst_rdata");
    chk(64'(a_err), 64'd0, "async_rst_error");
    chk(64'(a_stall), 64'd0, "async_rst_stall");
    clear_models();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) a_idle();
    a_req(1'b0, 64'h20, 64'h0, 1'b0);
    a_req(1'b0, 64'h18, 64'h0, 1'b1);
    a_idle();

    // Randomized traffic on A, mixing back-to-back and spaced requests
    in_resp = 1'b0;
    for (int i = 0; i < 24; i++) begin
      c = in_resp && ($urandom_range(0, 1) == 1);
      if (in_resp && !c) a_idle();
      a_req(1'($urandom_range(0, 1)), pick_addr(), rnd64(), c);
      in_resp = 1'b1;
    end
    a_idle();

    // LATENCY=1 instance with req_valid held high: one request per LATENCY+2 cycles
    acc_a = '0; acc_d = '0; acc_w = 1'b0;
    for (int n = 0; n < 10 * P; n++) begin
      b_valid = 1'b1; b_write = 1'($urandom_range(0, 1)); b_addr = pick_addr(); b_wdata = rnd64();
      #1;
      if (n > 0) begin
        ph = (n - 1) % P;
        if (ph == LAT_B) begin
          bad  = addr_bad(acc_a);
          widx = acc_a >> 3;
          chk(64'(b_rv), 64'd1, "b_resp_valid");
          chk(64'(b_err), 64'(bad), "b_resp_error");
          chk(b_rdata, (acc_w || bad) ? 64'd0 : ref_b[widx[7:0]], "b_resp_rdata");
          chk(64'(b_stall), 64'd0, "b_stall_resp");
          chk(64'(b_ready), 64'd0, "b_ready_resp");
          if (acc_w && !bad) ref_b[widx[7:0]] = acc_d;
        end else if (ph == LAT_B + 1) begin
          chk(64'(b_rv), 64'd0, "b_resp_valid_idle");
          chk(64'(b_ready), 64'd1, "b_ready_idle");
          chk(64'(b_stall), 64'd1, "b_stall_idle");
        end else begin
          chk(64'(b_rv), 64'd0, "b_resp_valid_wait");
          chk(64'(b_ready), 64'd0, "b_ready_wait");
          chk(64'(b_stall), 64'd1, "b_stall_wait");
        end
      end
      if (n % P == 0) begin
        acc_w = b_write; acc_a = b_addr; acc_d = b_wdata;
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    #1;
    chk(64'(b_rv), 64'd0, "b_resp_valid_end");
    chk(64'(b_ready), 64'd1, "b_ready_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
